// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational ALU between two requesters. Each requester has
//   a command channel (reqN_*) and a response channel (rspN_*). The block
//   runs one operation at a time through a three-state FSM:
//     IDLE  : pick a requester and accept its command
//     ISSUE : drive the stored command to the ALU, sample the ALU outputs
//     RESP  : present the result to the granted requester until it is taken
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once asserted, valid holds its payload until that transfer. Ready may
//   depend combinationally on valid. Ready or valid seen alone has no effect.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req0_valid/ready/opcode/a/b       requester 0 command channel
//   req1_valid/ready/opcode/a/b       requester 1 command channel
//   rsp0_valid/ready, rsp1_valid/ready response handshakes
//   rsp_result/overflow/error         shared response payload
//   alu_data_a/b, alu_opcode, alu_enable  drive to the shared ALU
//   alu_result/overflow/error         combinational ALU outputs
//
// Parameter:
//   PRIO_INIT  requester (0 or 1) holding round-robin priority after reset
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,

    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_error,

    output logic [31:0] alu_data_a,
    output logic [31:0] alu_data_b,
    output logic [4:0]  alu_opcode,
    output logic        alu_enable,

    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // NOP code of the shared opcode set: the ALU is not sampled for it.
    localparam logic [4:0] OP_NOP = 5'h00;

    logic [1:0]  state;
    logic        prio;       // requester that wins when both are valid
    logic        gnt_id;     // requester owning the operation in flight
    logic [4:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        grant_valid;
    logic        grant_sel;
    logic        rsp_take;

    // Grant decision. Gated by reset_n so no ready is shown while reset is
    // held; a grant can then only complete on a clock edge after release.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (reset_n && state == S_IDLE && (req0_valid || req1_valid)) begin
            grant_valid = 1'b1;
            grant_sel   = (req0_valid && req1_valid) ? prio : req1_valid;
        end
    end

    assign req0_ready = grant_valid && !grant_sel;
    assign req1_ready = grant_valid &&  grant_sel;

    assign rsp0_valid = (state == S_RESP) && !gnt_id;
    assign rsp1_valid = (state == S_RESP) &&  gnt_id;

    // Only the owner's ready can close the response.
    assign rsp_take = gnt_id ? rsp1_ready : rsp0_ready;

    // The ALU sees the stored command during ISSUE only; zero otherwise.
    always_comb begin
        alu_enable = 1'b0;
        alu_data_a = 32'd0;
        alu_data_b = 32'd0;
        alu_opcode = 5'd0;
        if (state == S_ISSUE) begin
            alu_enable = 1'b1;
            alu_data_a = a_q;
            alu_data_b = b_q;
            alu_opcode = op_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            prio         <= (PRIO_INIT != 0);
            gnt_id       <= 1'b0;
            op_q         <= 5'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rsp_result   <= 32'd0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        gnt_id <= grant_sel;
                        op_q   <= grant_sel ? req1_opcode : req0_opcode;
                        a_q    <= grant_sel ? req1_a      : req0_a;
                        b_q    <= grant_sel ? req1_b      : req0_b;
                        // Round robin: whoever just won yields priority.
                        prio   <= !grant_sel;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_q == OP_NOP) begin
                        rsp_result   <= 32'd0;
                        rsp_overflow <= 1'b0;
                        rsp_error    <= 1'b0;
                    end else begin
                        rsp_result   <= alu_result;
                        rsp_overflow <= alu_overflow;
                        rsp_error    <= alu_error;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_take) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
